// File: rtl/nmi_natv_xbar_if.sv
// NMI 1-to-N crossbar bundle: core-side request/response, fan-out slave bus and error reporting.
// The slave modport is the crossbar's view; master is the surrounding core/slave environment.
interface nmi_natv_xbar_if #(
  parameter int unsigned NUM_SLV = 13
) ();
  logic                    m_valid;
  logic [31:0]             m_addr;
  logic [31:0]             m_wdata;
  logic [3:0]              m_wstrb;
  logic                    m_ready;
  logic [31:0]             m_rdata;

  logic [NUM_SLV-1:0]      s_valid;
  logic [31:0]             s_addr;
  logic [31:0]             s_wdata;
  logic [3:0]              s_wstrb;
  logic [NUM_SLV-1:0]      s_ready;
  logic [NUM_SLV*32-1:0]   s_rdata;

  logic                    err_irq;
  logic                    err_clr;
  logic [1:0]              err_code;
  logic [31:0]             err_addr;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata, err_clr,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, err_irq, err_code, err_addr
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata, err_clr,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, err_irq, err_code, err_addr
  );
endinterface

// File: rtl/nmi_natv_xbar.sv
// NMI 1-to-N demux: base/mask address decode, one outstanding transaction, decode-error
// responder, per-transaction timeout and sticky first-error capture with interrupt.
module nmi_natv_xbar #(
  parameter int unsigned           NUM_SLV   = 13,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE  = {
    32'h1000_0C00, 32'h1000_0B00, 32'h1000_0A00, 32'h1000_0900, 32'h1000_0800,
    32'h1000_0700, 32'h1000_0600, 32'h1000_0500, 32'h1000_0400, 32'h1000_0300,
    32'h1000_0200, 32'h1000_0100, 32'h1000_0000},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK  = {13{32'hF000_FF00}},
  parameter int unsigned           TMO_CYC   = 1024,
  parameter logic [31:0]           ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               rst,
  nmi_natv_xbar_if.slave     bus
);

  localparam int unsigned SelW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CntW = $clog2(TMO_CYC);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic              hit;
  logic [SelW-1:0]   hit_idx;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic              err_new;
  logic [1:0]        err_new_code;
  logic [31:0]       err_new_addr;

  // Scan downwards so the lowest matching entry is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if (((bus.m_addr ^ SLV_BASE[k*32 +: 32]) & SLV_MASK[k*32 +: 32]) == 32'h0) begin
        hit     = 1'b1;
        hit_idx = SelW'(k);
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q == SelW'(k)) begin
        sel_ready = bus.s_ready[k];
        sel_rdata = bus.s_rdata[k*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    err_new      = 1'b0;
    err_new_code = 2'd0;
    err_new_addr = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.m_valid) begin
          if (hit) begin
            state_d = StBusy;
            sel_d   = hit_idx;
            cnt_d   = '0;
            addr_d  = bus.m_addr;
            wdata_d = bus.m_wdata;
            wstrb_d = bus.m_wstrb;
          end else begin
            state_d      = StResp;
            rdata_d      = ERR_RDATA;
            err_new      = 1'b1;
            err_new_code = 2'd1;
            err_new_addr = bus.m_addr;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        // Master abort outranks a same-cycle slave ready or timeout.
        if (!bus.m_valid) begin
          state_d = StIdle;
        end else if (sel_ready) begin
          state_d = StResp;
          rdata_d = sel_rdata;
        end else if (cnt_q == CntW'(TMO_CYC - 1)) begin
          state_d      = StResp;
          rdata_d      = ERR_RDATA;
          err_new      = 1'b1;
          err_new_code = 2'd2;
          err_new_addr = addr_q;
        end
      end
      StResp: begin
        state_d = StIdle;
        rdata_d = '0;
      end
      default: state_d = StIdle;
    endcase

    // First error is sticky; a clear coinciding with a new error lets the new one load.
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (err_new && (err_code_q == 2'd0 || bus.err_clr)) begin
      err_code_d = err_new_code;
      err_addr_d = err_new_addr;
    end else if (bus.err_clr) begin
      err_code_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      err_code_q <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    bus.s_valid = '0;
    if (state_q == StBusy) begin
      for (int k = 0; k < NUM_SLV; k++) begin
        bus.s_valid[k] = (sel_q == SelW'(k));
      end
    end
  end

  assign bus.m_ready  = (state_q == StResp);
  assign bus.m_rdata  = rdata_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;
  assign bus.s_wstrb  = wstrb_q;
  assign bus.err_code = err_code_q;
  assign bus.err_addr = err_addr_q;
  assign bus.err_irq  = (err_code_q != 2'd0);

endmodule

// File: tb/tb_nmi_natv_xbar.sv
// Directed bench for nmi_natv_xbar: hit read/write, decode miss, timeout, sticky errors,
// clear/new-error collision, master abort and mid-transaction reset.
module tb_nmi_natv_xbar;

  localparam int unsigned NumSlv = 13;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;

  nmi_natv_xbar_if #(.NUM_SLV(NumSlv)) bus ();

  nmi_natv_xbar #(
    .NUM_SLV (NumSlv),
    .TMO_CYC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.m_valid = 1'b1;
    bus.m_addr  = a;
    bus.m_wdata = d;
    bus.m_wstrb = s;
  endtask

  task automatic idle_master();
    bus.m_valid = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_master();
    bus.err_clr = 1'b0;
    bus.s_ready = '0;
    for (int k = 0; k < NumSlv; k++) bus.s_rdata[k*32 +: 32] = 32'hA5A5_0000 | 32'(k);
    tick();
    tick();

    // Reset state
    chk("rst_mready", 32'(bus.m_ready), 32'd0);
    chk("rst_mrdata", bus.m_rdata, 32'd0);
    chk("rst_svalid", 32'(bus.s_valid), 32'd0);
    chk("rst_saddr", bus.s_addr, 32'd0);
    chk("rst_irq", 32'(bus.err_irq), 32'd0);
    chk("rst_ecode", 32'(bus.err_code), 32'd0);
    chk("rst_eaddr", bus.err_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Read hit on slave 2, ready on the 4th s_valid cycle; slave 3 ready is noise
    req(32'h1000_0200, 32'h0, 4'h0);
    bus.s_ready[3] = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk("rd_svalid", 32'(bus.s_valid), 32'h0000_0004);
      chk("rd_mready_lo", 32'(bus.m_ready), 32'd0);
      if (i == 4) bus.s_ready[2] = 1'b1;
      tick();
    end
    chk("rd_svalid_drop", 32'(bus.s_valid), 32'd0);
    chk("rd_mready", 32'(bus.m_ready), 32'd1);
    chk("rd_rdata", bus.m_rdata, 32'hA5A5_0002);
    idle_master();
    bus.s_ready = '0;
    tick();
    chk("rd_mready_end", 32'(bus.m_ready), 32'd0);
    chk("rd_rdata_end", bus.m_rdata, 32'd0);

    // Write hit on slave 12 with ready already high
    req(32'h1000_0C04, 32'h1234_5678, 4'hF);
    bus.s_ready[12] = 1'b1;
    tick();
    chk("wr_svalid", 32'(bus.s_valid), 32'h0000_1000);
    chk("wr_saddr", bus.s_addr, 32'h1000_0C04);
    chk("wr_swdata", bus.s_wdata, 32'h1234_5678);
    chk("wr_swstrb", 32'(bus.s_wstrb), 32'hF);
    chk("wr_mready_lo", 32'(bus.m_ready), 32'd0);
    tick();
    chk("wr_mready", 32'(bus.m_ready), 32'd1);
    chk("wr_rdata", bus.m_rdata, 32'hA5A5_000C);
    chk("wr_ecode", 32'(bus.err_code), 32'd0);
    idle_master();
    bus.s_ready = '0;
    tick();

    // Decode miss
    req(32'h1000_1F00, 32'h0, 4'h0);
    tick();
    chk("miss_svalid", 32'(bus.s_valid), 32'd0);
    chk("miss_mready", 32'(bus.m_ready), 32'd1);
    chk("miss_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    chk("miss_ecode", 32'(bus.err_code), 32'd1);
    chk("miss_eaddr", bus.err_addr, 32'h1000_1F00);
    chk("miss_irq", 32'(bus.err_irq), 32'd1);
    idle_master();
    tick();

    // Timeout on slave 5 with an earlier miss still pending
    req(32'h1000_0500, 32'h0, 4'h0);
    tick();
    n = 0;
    while (bus.s_valid == 13'h0020 && n < 40) begin
      n++;
      tick();
    end
    chk("tmo1_cycles", 32'(n), 32'd16);
    chk("tmo1_svalid", 32'(bus.s_valid), 32'd0);
    chk("tmo1_mready", 32'(bus.m_ready), 32'd1);
    chk("tmo1_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    chk("tmo1_ecode_kept", 32'(bus.err_code), 32'd1);
    chk("tmo1_eaddr_kept", bus.err_addr, 32'h1000_1F00);
    idle_master();
    tick();

    // Clear, then a second timeout is recorded
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("clr_ecode", 32'(bus.err_code), 32'd0);
    chk("clr_irq", 32'(bus.err_irq), 32'd0);
    req(32'h1000_0500, 32'h0, 4'h0);
    tick();
    n = 0;
    while (bus.s_valid == 13'h0020 && n < 40) begin
      n++;
      tick();
    end
    chk("tmo2_cycles", 32'(n), 32'd16);
    chk("tmo2_mready", 32'(bus.m_ready), 32'd1);
    chk("tmo2_ecode", 32'(bus.err_code), 32'd2);
    chk("tmo2_eaddr", bus.err_addr, 32'h1000_0500);
    chk("tmo2_irq", 32'(bus.err_irq), 32'd1);
    idle_master();
    tick();

    // Clear coinciding with a new miss: the miss wins
    req(32'h1000_2000, 32'h0, 4'h0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("coll_ecode", 32'(bus.err_code), 32'd1);
    chk("coll_irq", 32'(bus.err_irq), 32'd1);
    chk("coll_eaddr", bus.err_addr, 32'h1000_2000);
    idle_master();
    tick();

    // Master abort in the second BUSY cycle
    req(32'h1000_0700, 32'h0, 4'h0);
    tick();
    chk("abt_svalid1", 32'(bus.s_valid), 32'h0000_0080);
    tick();
    chk("abt_svalid2", 32'(bus.s_valid), 32'h0000_0080);
    idle_master();
    tick();
    chk("abt_svalid_drop", 32'(bus.s_valid), 32'd0);
    chk("abt_mready1", 32'(bus.m_ready), 32'd0);
    tick();
    chk("abt_mready2", 32'(bus.m_ready), 32'd0);

    // Reset while BUSY
    req(32'h1000_0104, 32'hCAFE_F00D, 4'h3);
    tick();
    chk("rb_svalid", 32'(bus.s_valid), 32'h0000_0002);
    rst = 1'b1;
    idle_master();
    tick();
    chk("rb_svalid_rst", 32'(bus.s_valid), 32'd0);
    chk("rb_saddr_rst", bus.s_addr, 32'd0);
    chk("rb_swdata_rst", bus.s_wdata, 32'd0);
    chk("rb_swstrb_rst", 32'(bus.s_wstrb), 32'd0);
    chk("rb_mready_rst", 32'(bus.m_ready), 32'd0);
    chk("rb_ecode_rst", 32'(bus.err_code), 32'd0);
    chk("rb_eaddr_rst", bus.err_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Normal request after reset, slave 0 ready immediately
    req(32'h1000_0010, 32'h0, 4'h0);
    bus.s_ready[0] = 1'b1;
    tick();
    chk("post_svalid", 32'(bus.s_valid), 32'h0000_0001);
    tick();
    chk("post_mready", 32'(bus.m_ready), 32'd1);
    chk("post_rdata", bus.m_rdata, 32'hA5A5_0000);
    idle_master();
    bus.s_ready = '0;
    tick();
    chk("post_mready_end", 32'(bus.m_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nmi_natv_xbar.md
Name: nmi_natv_xbar

Overview:
Parametrised NMI 1-to-N demultiplexer that replaces hand-written per-IP valid/ready/rdata decode in the native-IP wrapper. It decodes the master address against a base/mask table and forwards one transaction at a time to the selected slave, with registered request and response paths. It adds a decode-error responder, a per-transaction timeout and sticky error reporting with an interrupt, so unmapped or hung slaves cannot stall the core.

Parameters:
NUM_SLV, 13, number of slave ports (1..32)
SLV_BASE, {k: 32'h1000_0000 | (k<<8)}, packed NUM_SLV x 32 base-address table
SLV_MASK, {k: 32'hF000_FF00}, packed NUM_SLV x 32 compare-mask table
TMO_CYC, 1024, cycles to wait for s_ready before abort (>=2)
ERR_RDATA, 32'hDEAD_BEEF, rdata returned on decode error or timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
m_valid_i  in  1  master request valid, held until m_ready_o
m_addr_i  in  32  master address
m_wdata_i  in  32  write data
m_wstrb_i  in  4  byte strobes; 0 = read
m_ready_o  out  1  one-cycle response strobe
m_rdata_o  out  32  response data, valid with m_ready_o
s_valid_o  out  NUM_SLV  one-hot slave valid
s_addr_o  out  32  latched address, shared by all slaves
s_wdata_o  out  32  latched write data, shared
s_wstrb_o  out  4  latched strobes, shared
s_ready_i  in  NUM_SLV  slave ready
s_rdata_i  in  NUM_SLV*32  slave rdata; slot k = bits [32k+31:32k]
err_irq_o  out  1  sticky error interrupt
err_clr_i  in  1  clears err_irq_o and err_code_o
err_code_o  out  2  0 none, 1 decode miss, 2 timeout
err_addr_o  out  32  address of the first unacknowledged error

Behaviour:
- Clock and reset: clk_i is the single clock; rst_i is synchronous and active-high.
- Reset: state IDLE. m_ready_o=0, m_rdata_o=0, s_valid_o=0, s_addr/wdata/wstrb=0, err_irq_o=0, err_code_o=0, err_addr_o=0, timeout counter=0.
- Decode: hit[k] = ((m_addr_i ^ SLV_BASE[k]) & SLV_MASK[k]) == 0. Lowest hit index wins if entries overlap.
- IDLE, m_valid_i=1, any hit: latch addr/wdata/wstrb and sel=index. Go to BUSY. s_valid_o[sel]=1 from the next cycle.
- IDLE, m_valid_i=1, no hit: go to RESP with m_rdata=ERR_RDATA and error code 1.
- BUSY:
  - Counter increments each cycle.
  - If s_ready_i[sel]=1: register s_rdata_i slot sel, drop s_valid_o, go to RESP.
  - If counter reaches TMO_CYC-1 without ready: drop s_valid_o, rdata=ERR_RDATA, error code 2, go to RESP.
  - If m_valid_i falls while BUSY (master abort): drop s_valid_o and go to IDLE with no response.
- s_ready_i on non-selected slaves, or while not BUSY, is ignored.
- RESP: m_ready_o=1 for exactly one cycle with m_rdata_o, then IDLE. m_rdata_o returns to 0 when m_ready_o=0.
- A new request is accepted in the IDLE cycle following RESP. Throughput is at most one transaction per 3 cycles.
- Latency on a hit: request at cycle 0, s_valid_o at cycle 1; if s_ready_i is seen at cycle n, m_ready_o is at cycle n+1. Minimum 3 cycles.
- Errors:
  - On entering RESP with an error: if err_code_o==0, load err_code_o and err_addr_o; otherwise keep the first error.
  - err_irq_o=1 while err_code_o!=0.
  - err_clr_i clears err_code_o. If err_clr_i and a new error coincide, the new error wins (loaded, irq stays 1).
- Timeout counter resets on every IDLE->BUSY transition.
- Reset asserted mid-transaction: immediate return to reset values, no response issued.

Test Plan:
- Read hit: m_addr=32'h1000_0200, wstrb=0; slave 2 asserts ready 4 cycles after its s_valid with rdata 32'hA5A5_0002 -> s_valid_o=13'b0_0000_0000_0100 for 4 cycles; m_ready_o one cycle later with rdata 32'hA5A5_0002; no other s_valid bit set.
- Write hit: m_addr=32'h1000_0C04, wdata=32'h1234_5678, wstrb=4'hF; slave 12 ready immediately -> s_addr_o/s_wdata_o/s_wstrb_o match; m_ready_o at cycle 3.
- Decode miss: m_addr=32'h1000_1F00 -> no s_valid; m_ready_o at cycle 2 with 32'hDEAD_BEEF; err_code_o=1, err_addr_o=32'h1000_1F00, err_irq_o=1.
- Timeout: TMO_CYC=16, slave 5 never ready -> s_valid_o[5] high 16 cycles then low; m_ready_o with 32'hDEAD_BEEF. With err_code already 1, err_code stays 1; after err_clr_i plus another timeout, err_code_o=2.
- Simultaneous err_clr_i and new miss in the same cycle -> err_code_o=1, err_irq_o stays 1.
- Master abort and reset: drop m_valid_i in BUSY cycle 2 -> s_valid_o=0 next cycle, no m_ready_o. Assert rst_i in BUSY -> all outputs 0 next cycle; a later request completes normally.
